ififo_skew_reader: RTL and testbench
====================================

IFIFO_SKEW_READER -- requirements
Module: ififo_skew_reader

Interface
REQ-001 SHALL have parameter col, default 8: number of column FIFOs and array columns.
REQ-002 SHALL have parameter bw, default 4: word width per column.
REQ-003 SHALL have parameter len_w, default 7: width of the vector-count field, covering 0..64.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset is synchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle job request; ignored while busy.
REQ-007 SHALL have port num_vec, input, len_w: words per column for the job; sampled on an accepted start.
REQ-008 SHALL have port fifo_data, input, col*bw: head word of each column FIFO (first-word-fall-through); column c occupies bits [(c+1)*bw-1 : c*bw].
REQ-009 SHALL have port fifo_valid, input, col: per-column FIFO non-empty.
REQ-010 SHALL have port array_stall, input, 1: PE array backpressure.
REQ-011 SHALL have port rd_en, output, col: per-column pop strobe to the FIFO bank.
REQ-012 SHALL have port arr_data, output, col*bw: registered skewed words to the array.
REQ-013 SHALL have port arr_valid, output, col: per-column valid for arr_data.
REQ-014 SHALL have port busy, output, 1: job in progress.
REQ-015 SHALL have port done, output, 1: one-cycle job-complete pulse.
REQ-016 SHALL have port starve, output, 1: the current tick is blocked by an empty FIFO that the tick needs.

Function
REQ-017 SHALL implement states IDLE, RUN and FINISH.
- IDLE -> RUN on start with num_vec > 0.
- IDLE -> FINISH on start with num_vec == 0.
- RUN -> FINISH after the last tick.
- FINISH -> IDLE unconditionally after one cycle.
REQ-018 SHALL keep a tick counter t, cleared on accepted start, incremented only on an advancing tick.
REQ-019 SHALL treat column c as active at tick t when c <= t < c + num_vec; this produces a diagonal skew of one tick per column.
REQ-020 SHALL advance a tick when all of the following hold: state is RUN, array_stall is 0, and fifo_valid[c] is 1 for every active c.
REQ-021 SHALL assert rd_en[c] combinationally in an advancing-tick cycle only, for active columns only; inactive columns never pop.
REQ-022 SHALL, on an advancing tick, register fifo_data into arr_data for active columns and set their arr_valid bits; inactive columns get arr_valid 0 and data 0. Latency is one cycle from rd_en to arr_valid.
REQ-023 SHALL, in non-advancing cycles, drive arr_valid to all-zero and hold arr_data.
REQ-024 SHALL end a job after exactly num_vec + col - 1 advancing ticks; column c pops exactly num_vec words.
REQ-025 SHALL assert starve in RUN when array_stall is 0 but some active column has fifo_valid 0.
REQ-026 SHALL give array_stall priority: when array_stall is 1, starve is 0.
REQ-027 SHALL assert busy in RUN and FINISH, and pulse done for the single FINISH cycle.
REQ-028 SHALL ignore start while busy: no restart and no change to num_vec.
REQ-029 SHALL NOT pop or drive invalid data when a FIFO goes empty mid-job; the whole tick holds, which preserves the skew alignment.

Reset
REQ-030 SHALL, when reset == 0 at a clock edge, enter IDLE with t = 0, arr_data = 0, arr_valid = 0, busy = 0, done = 0 and the latched num_vec = 0.
REQ-031 SHALL hold rd_en = 0 and starve = 0 combinationally while in IDLE, including during reset.
REQ-032 SHALL abort a job on reset asserted mid-job, with no further pops and no done pulse.

Structure
REQ-033 SHALL place the state encoding and the default col/bw/len_w constants in a shared package that is also used by the FIFO bank and the array top.
REQ-034 SHALL allow one sub-module, ififo_col_gate (per column): inputs t, num_vec, column index and fifo_valid; outputs active and need_ok. Generated col times.

Verification
REQ-035 SHALL cover: col=8, num_vec=4, all FIFOs pre-filled, no stall -> 11 ticks; rd_en[c] high during ticks c..c+3; done at cycle 12 after start; each column sees its 4 words in order.
REQ-036 SHALL cover: num_vec=0 start -> no rd_en; busy for 1 cycle, then done pulse.
REQ-037 SHALL cover: array_stall held for 3 cycles at tick 5 -> t holds at 5; rd_en=0 and arr_valid=0 for those 3 cycles; starve=0; total advancing ticks still 11.
REQ-038 SHALL cover: fifo_valid[3]=0 at tick 4 for 2 cycles -> starve=1 for 2 cycles, no column pops, then resume with the skew intact.
REQ-039 SHALL cover: second start during RUN -> ignored; pop count per column equals the first job's num_vec.
REQ-040 SHALL cover: reset=0 at tick 6 -> next cycle all outputs 0; a subsequent start with num_vec=2 completes in 9 ticks.

Source files
------------

// File: rtl/ififo_skew_reader_pkg.sv
// rtl/ififo_skew_reader_pkg.sv - shared state encoding and default sizing for the skew reader
package ififo_skew_reader_pkg;

  localparam int COL_DEF   = 8;
  localparam int BW_DEF    = 4;
  localparam int LEN_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Tick counter must reach num_vec + col - 1 without wrapping.
  function automatic int tick_w(input int len_w, input int col);
    return len_w + $clog2(col) + 1;
  endfunction

endpackage

// File: rtl/ififo_col_gate.sv
// rtl/ififo_col_gate.sv - per-column activity window and FIFO readiness for one tick
module ififo_col_gate
  import ififo_skew_reader_pkg::*;
#(
  parameter int tw    = tick_w(LEN_W_DEF, COL_DEF),
  parameter int len_w = LEN_W_DEF
) (
  input  logic [tw-1:0]    t,
  input  logic [len_w-1:0] num_vec,
  input  logic [tw-1:0]    idx,
  input  logic             fifo_valid,
  output logic             active,
  output logic             need_ok
);

  logic [tw-1:0] end_t;

  // Column idx streams during ticks idx .. idx+num_vec-1; a column outside
  // its window never blocks the tick.
  always_comb begin
    end_t   = idx + tw'(num_vec);
    active  = (t >= idx) && (t < end_t);
    need_ok = !active || fifo_valid;
  end

endmodule

// File: rtl/ififo_skew_reader.sv
// rtl/ififo_skew_reader.sv - reads column FIFOs with a one-tick-per-column diagonal skew
module ififo_skew_reader
  import ififo_skew_reader_pkg::*;
#(
  parameter int col   = COL_DEF,
  parameter int bw    = BW_DEF,
  parameter int len_w = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [len_w-1:0]    num_vec,
  input  logic [col*bw-1:0]   fifo_data,
  input  logic [col-1:0]      fifo_valid,
  input  logic                array_stall,
  output logic [col-1:0]      rd_en,
  output logic [col*bw-1:0]   arr_data,
  output logic [col-1:0]      arr_valid,
  output logic                busy,
  output logic                done,
  output logic                starve
);

  localparam int TW = tick_w(len_w, col);

  state_t           state, state_nxt;
  logic [TW-1:0]    t;
  logic [TW-1:0]    t_last;
  logic [len_w-1:0] nv;
  logic [col-1:0]   active;
  logic [col-1:0]   need_ok;
  logic             all_ok;
  logic             accept;
  logic             advance;
  logic             last_tick;

  for (genvar g = 0; g < col; g++) begin : g_gate
    ififo_col_gate #(.tw(TW), .len_w(len_w)) u_gate (
      .t          (t),
      .num_vec    (nv),
      .idx        (TW'(g)),
      .fifo_valid (fifo_valid[g]),
      .active     (active[g]),
      .need_ok    (need_ok[g])
    );
  end

  // Tick qualification: a tick moves only as a whole, so an empty FIFO or a
  // stall freezes every column and the diagonal stays aligned. Reset gates
  // pops and starve so nothing leaks out before the state register clears.
  always_comb begin
    all_ok    = &need_ok;
    accept    = reset && start && (state == ST_IDLE);
    advance   = reset && (state == ST_RUN) && !array_stall && all_ok;
    t_last    = TW'(nv) + TW'(col) - TW'(1);
    last_tick = advance && ((t + TW'(1)) == t_last);
    rd_en     = advance ? active : '0;
    starve    = reset && (state == ST_RUN) && !array_stall && !all_ok;
    busy      = (state != ST_IDLE);
    done      = (state == ST_FINISH);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = (num_vec == '0) ? ST_FINISH : ST_RUN;
      ST_RUN:    if (last_tick) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Job length latch and tick counter; start while busy leaves both alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      t  <= '0;
      nv <= '0;
    end else if (accept) begin
      t  <= '0;
      nv <= num_vec;
    end else if (advance) begin
      t  <= t + TW'(1);
    end
  end

  // Output register: capture active heads on an advancing tick, zero the
  // inactive lanes, and hold data with valid dropped otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      arr_data  <= '0;
      arr_valid <= '0;
    end else if (advance) begin
      arr_valid <= active;
      for (int c = 0; c < col; c++) begin
        arr_data[c*bw +: bw] <= active[c] ? fifo_data[c*bw +: bw] : '0;
      end
    end else begin
      arr_valid <= '0;
    end
  end

endmodule

// File: tb/tb_ififo_skew_reader.sv
// tb/tb_ififo_skew_reader.sv - scoreboard bench for the skew reader
module tb_ififo_skew_reader;

  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int LW  = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LW-1:0]     num_vec;
  logic [COL*BW-1:0] fifo_data;
  logic [COL-1:0]    fifo_valid;
  logic              array_stall;
  logic [COL-1:0]    rd_en;
  logic [COL*BW-1:0] arr_data;
  logic [COL-1:0]    arr_valid;
  logic              busy;
  logic              done;
  logic              starve;

  typedef struct packed {
    logic [COL-1:0]    m;
    logic [COL*BW-1:0] d;
  } exp_t;

  exp_t         sb[$];
  logic [BW-1:0] mem [COL][128];
  int           head [COL];
  int           fill [COL];
  logic [COL-1:0] voff;
  int           tests;
  int           fails;
  int           ticks;

  always #5 clk = ~clk;

  ififo_skew_reader #(.col(COL), .bw(BW), .len_w(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_vec     (num_vec),
    .fifo_data   (fifo_data),
    .fifo_valid  (fifo_valid),
    .array_stall (array_stall),
    .rd_en       (rd_en),
    .arr_data    (arr_data),
    .arr_valid   (arr_valid),
    .busy        (busy),
    .done        (done),
    .starve      (starve)
  );

  for (genvar c = 0; c < COL; c++) begin : g_fifo
    assign fifo_data[c*BW +: BW] = mem[c][head[c]];
    assign fifo_valid[c]         = (head[c] < fill[c]) && !voff[c];
  end

  always @(posedge clk) begin
    for (int c = 0; c < COL; c++) if (rd_en[c] === 1'b1) head[c] <= head[c] + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented tick must match the next expected diagonal slice.
  always @(negedge clk) begin
    if (arr_valid != '0) begin
      ticks++;
      if (sb.size() == 0) begin
        chk("unexpected_tick", 64'(arr_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tick_mask", 64'(arr_valid), 64'(e.m));
        chk("tick_data", 64'(arr_data), 64'(e.d));
      end
    end
  end

  function automatic logic [BW-1:0] wd(input int c, input int n);
    return BW'((c * 5 + n * 3 + 1) & 15);
  endfunction

  task automatic load(input int nv);
    int   base [COL];
    exp_t e;
    for (int c = 0; c < COL; c++) begin
      base[c] = fill[c];
      for (int k = 0; k < nv; k++) mem[c][fill[c] + k] = wd(c, fill[c] + k);
      fill[c] = fill[c] + nv;
    end
    if (nv > 0) begin
      for (int k = 0; k < nv + COL - 1; k++) begin
        e = '0;
        for (int c = 0; c < COL; c++) begin
          if (k >= c && k < c + nv) begin
            e.m[c] = 1'b1;
            e.d[c*BW +: BW] = wd(c, base[c] + k - c);
          end
        end
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_job(input int nv, input int st_cyc, input int st_len,
                         input int sv_col, input int sv_cyc, input int sv_len,
                         input int rs_cyc, input int ab_cyc, input int exp_done,
                         input string nm);
    int cnt;
    int t0;
    int h0 [COL];
    bit got;
    bit aborted;
    load(nv);
    t0 = ticks;
    for (int c = 0; c < COL; c++) h0[c] = head[c];
    @(posedge clk); #1;
    start = 1'b1; num_vec = LW'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; got = 0; aborted = 0;
    while (!got && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (ab_cyc > 0 && cnt == ab_cyc + 1) begin
        chk({nm, "_abort_rd_en"}, 64'(rd_en), 64'(0));
        chk({nm, "_abort_valid"}, 64'(arr_valid), 64'(0));
        chk({nm, "_abort_data"}, 64'(arr_data), 64'(0));
        chk({nm, "_abort_busy"}, 64'(busy), 64'(0));
        chk({nm, "_abort_done"}, 64'(done), 64'(0));
        chk({nm, "_abort_starve"}, 64'(starve), 64'(0));
        reset = 1'b1;
        sb.delete();
        for (int c = 0; c < COL; c++) fill[c] = head[c];
        got = 1; aborted = 1;
      end else begin
        if (cnt == 1) chk({nm, "_busy_first"}, 64'(busy), 64'(1));
        if (done === 1'b1) begin
          got = 1;
          chk({nm, "_done_cycle"}, 64'(cnt), 64'(exp_done));
        end
        if (cnt > st_cyc && cnt <= st_cyc + st_len) begin
          chk({nm, "_stall_rd_en"}, 64'(rd_en), 64'(0));
          chk({nm, "_stall_valid"}, 64'(arr_valid), 64'(0));
          chk({nm, "_stall_starve"}, 64'(starve), 64'(0));
        end
        if (cnt > sv_cyc && cnt <= sv_cyc + sv_len) begin
          chk({nm, "_starve_flag"}, 64'(starve), 64'(1));
          chk({nm, "_starve_rd_en"}, 64'(rd_en), 64'(0));
        end
        if (cnt == st_cyc) array_stall = 1'b1;
        if (cnt == st_cyc + st_len) array_stall = 1'b0;
        if (cnt == sv_cyc) voff[sv_col] = 1'b1;
        if (cnt == sv_cyc + sv_len) voff = '0;
        if (cnt == rs_cyc) begin start = 1'b1; num_vec = LW'(2); end
        if (cnt == rs_cyc + 1) begin start = 1'b0; num_vec = LW'(nv); end
        if (cnt == ab_cyc) reset = 1'b0;
      end
    end
    if (!got) chk({nm, "_timeout"}, 64'(cnt), 64'(exp_done));
    @(negedge clk);
    chk({nm, "_done_low"}, 64'(done), 64'(0));
    chk({nm, "_idle"}, 64'(busy), 64'(0));
    if (!aborted) begin
      chk({nm, "_ticks"}, 64'(ticks - t0), 64'((nv > 0) ? nv + COL - 1 : 0));
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'(0));
      for (int c = 0; c < COL; c++) chk({nm, "_pops"}, 64'(head[c] - h0[c]), 64'(nv));
    end
  endtask

  initial begin
    tests = 0; fails = 0; ticks = 0;
    reset = 1'b0; start = 1'b0; num_vec = '0; array_stall = 1'b0; voff = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_valid", 64'(arr_valid), 64'(0));
    chk("rst_data", 64'(arr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_starve", 64'(starve), 64'(0));
    reset = 1'b1;

    run_job(4, -9, 0, 0, -9, 0, -9, -9, 12, "base");
    run_job(0, -9, 0, 0, -9, 0, -9, -9, 1, "zero");
    run_job(4, 6, 3, 0, -9, 0, -9, -9, 15, "stall");
    run_job(4, -9, 0, 3, 5, 2, -9, -9, 14, "starve");
    run_job(4, -9, 0, 0, -9, 0, 4, -9, 12, "restart");
    run_job(4, -9, 0, 0, -9, 0, -9, 7, 0, "abort");
    run_job(2, -9, 0, 0, -9, 0, -9, -9, 10, "after_abort");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
